// File: rtl/nanorv32_bus_arb.sv
// nanorv32_bus_arb: lets the nanorv32 I and D AHB-lite ports share one master port.
// Build option NANORV32_ARB_RR_EN selects round-robin contests instead of D priority with a starvation limit.
module nanorv32_bus_arb #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    // instruction-fetch port
    input  logic [1:0]  i_htrans,
    input  logic [31:0] i_haddr,
    input  logic [2:0]  i_hsize,
    output logic        i_hready,
    output logic [31:0] i_hrdata,
    output logic        i_hresp,
    // data port
    input  logic [1:0]  d_htrans,
    input  logic [31:0] d_haddr,
    input  logic        d_hwrite,
    input  logic [2:0]  d_hsize,
    input  logic [31:0] d_hwdata,
    output logic        d_hready,
    output logic [31:0] d_hrdata,
    output logic        d_hresp,
    // shared bus
    output logic [1:0]  m_htrans,
    output logic [31:0] m_haddr,
    output logic        m_hwrite,
    output logic [2:0]  m_hsize,
    output logic [31:0] m_hwdata,
    input  logic        m_hready,
    input  logic [31:0] m_hrdata,
    input  logic        m_hresp,
    output logic [1:0]  arb_owner
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_I    = 2'd1,
        OWN_D    = 2'd2
    } owner_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    logic        pend_i_q, pend_i_d;
    logic [31:0] pend_i_addr_q, pend_i_addr_d;
    logic [2:0]  pend_i_size_q, pend_i_size_d;

    logic        pend_d_q, pend_d_d;
    logic [31:0] pend_d_addr_q, pend_d_addr_d;
    logic [2:0]  pend_d_size_q, pend_d_size_d;
    logic        pend_d_write_q, pend_d_write_d;

    owner_e      owner_q, owner_d;

`ifdef NANORV32_ARB_RR_EN
    logic        last_grant_q, last_grant_d;   // 0: I granted last, 1: D granted last
`else
    logic [3:0]  starve_cnt_q, starve_cnt_d;
`endif

    logic        i_acc, d_acc;
    logic        i_cand, d_cand;
    logic        win_i, win_d;
    logic        unused_htrans_lsb;

    // SEQ and NONSEQ are handled alike, so only htrans[1] matters
    assign unused_htrans_lsb = i_htrans[0] ^ d_htrans[0];

    assign m_hwdata  = d_hwdata;
    assign arb_owner = owner_q;

    // Per-master response: the data-phase owner sees the slave, others see hold-off
    always_comb begin
        i_hready = !pend_i_q;
        i_hresp  = 1'b0;
        i_hrdata = '0;
        if (owner_q == OWN_I) begin
            i_hready = m_hready;
            i_hresp  = m_hresp;
            i_hrdata = m_hrdata;
        end
    end

    always_comb begin
        d_hready = !pend_d_q;
        d_hresp  = 1'b0;
        d_hrdata = '0;
        if (owner_q == OWN_D) begin
            d_hready = m_hready;
            d_hresp  = m_hresp;
            d_hrdata = m_hrdata;
        end
    end

    // Live requests are only taken while the master sees HREADY high and has nothing buffered
    always_comb begin
        i_acc  = !rst && i_htrans[1] && i_hready && !pend_i_q;
        d_acc  = !rst && d_htrans[1] && d_hready && !pend_d_q;
        i_cand = pend_i_q || i_acc;
        d_cand = pend_d_q || d_acc;
    end

    always_comb begin
        win_i = i_cand;
        win_d = d_cand;
        if (i_cand && d_cand) begin
`ifdef NANORV32_ARB_RR_EN
            win_i = last_grant_q;
`else
            win_i = (starve_cnt_q == 4'(STARVE_LIMIT));
`endif
            win_d = !win_i;
        end
    end

    // The winner is driven every cycle; during wait states it stays stable because the state is frozen
    always_comb begin
        m_htrans = HTRANS_IDLE;
        m_haddr  = '0;
        m_hsize  = '0;
        m_hwrite = 1'b0;
        if (win_d) begin
            m_htrans = HTRANS_NONSEQ;
            m_haddr  = pend_d_q ? pend_d_addr_q  : d_haddr;
            m_hsize  = pend_d_q ? pend_d_size_q  : d_hsize;
            m_hwrite = pend_d_q ? pend_d_write_q : d_hwrite;
        end else if (win_i) begin
            m_htrans = HTRANS_NONSEQ;
            m_haddr  = pend_i_q ? pend_i_addr_q : i_haddr;
            m_hsize  = pend_i_q ? pend_i_size_q : i_hsize;
        end
    end

    always_comb begin
        pend_i_d       = pend_i_q;
        pend_i_addr_d  = pend_i_addr_q;
        pend_i_size_d  = pend_i_size_q;
        pend_d_d       = pend_d_q;
        pend_d_addr_d  = pend_d_addr_q;
        pend_d_size_d  = pend_d_size_q;
        pend_d_write_d = pend_d_write_q;
        owner_d        = owner_q;

        // An accepted request that is not granted this cycle must be kept, even during wait states
        if (m_hready && win_i) begin
            pend_i_d = 1'b0;
        end else if (i_acc) begin
            pend_i_d      = 1'b1;
            pend_i_addr_d = i_haddr;
            pend_i_size_d = i_hsize;
        end

        if (m_hready && win_d) begin
            pend_d_d = 1'b0;
        end else if (d_acc) begin
            pend_d_d       = 1'b1;
            pend_d_addr_d  = d_haddr;
            pend_d_size_d  = d_hsize;
            pend_d_write_d = d_hwrite;
        end

        if (m_hready) begin
            if (win_d)      owner_d = OWN_D;
            else if (win_i) owner_d = OWN_I;
            else            owner_d = OWN_NONE;
        end
    end

`ifdef NANORV32_ARB_RR_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (m_hready && win_d)      last_grant_d = 1'b1;
        else if (m_hready && win_i) last_grant_d = 1'b0;
    end
`else
    always_comb begin
        starve_cnt_d = starve_cnt_q;
        if (m_hready) begin
            if (win_i)                starve_cnt_d = 4'd0;
            else if (win_d && i_cand) starve_cnt_d = starve_cnt_q + 4'd1;
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_i_q     <= 1'b0;
            pend_d_q     <= 1'b0;
            owner_q      <= OWN_NONE;
`ifdef NANORV32_ARB_RR_EN
            last_grant_q <= 1'b0;
`else
            starve_cnt_q <= 4'd0;
`endif
        end else begin
            pend_i_q     <= pend_i_d;
            pend_d_q     <= pend_d_d;
            owner_q      <= owner_d;
`ifdef NANORV32_ARB_RR_EN
            last_grant_q <= last_grant_d;
`else
            starve_cnt_q <= starve_cnt_d;
`endif
        end
        pend_i_addr_q  <= pend_i_addr_d;
        pend_i_size_q  <= pend_i_size_d;
        pend_d_addr_q  <= pend_d_addr_d;
        pend_d_size_q  <= pend_d_size_d;
        pend_d_write_q <= pend_d_write_d;
    end

endmodule

// File: doc/nanorv32_bus_arb.md
# nanorv32_bus_arb

Two-master, one-slave AHB-lite arbiter letting the nanorv32 instruction-fetch port (I) and data port (D) share a single AHB-lite master port, as used by single-ported memory configurations. It sits between the core's code/data interfaces and the system bus. It buffers address phases that lose arbitration, holds the losing master with HREADY low, and forwards each transfer once the shared bus is free. D has priority, with a starvation limit that protects instruction fetch.

## Interface
- STARVE_LIMIT, 4, consecutive contested D wins before I is forced through (1..15)
- clk  in  1  clock
- rst  in  1  reset; synchronous and active-high (the `clk` / `rst` names follow the codebase; polarity and synchronicity are fixed)
- i_htrans  in  2  I transfer type
- i_haddr  in  32  I address
- i_hsize  in  3  I size; I is read-only
- i_hready  out  1  I transfer ready
- i_hrdata  out  32  I read data
- i_hresp  out  1  I error response
- d_htrans  in  2  D transfer type
- d_haddr  in  32  D address
- d_hwrite  in  1  D write
- d_hsize  in  3  D size
- d_hwdata  in  32  D write data
- d_hready  out  1  D transfer ready
- d_hrdata  out  32  D read data
- d_hresp  out  1  D error response
- m_htrans  out  2  shared-bus transfer type
- m_haddr  out  32  shared-bus address
- m_hwrite  out  1  shared-bus write
- m_hsize  out  3  shared-bus size
- m_hwdata  out  32  shared-bus write data, always equal to d_hwdata
- m_hready  in  1  shared-bus ready
- m_hrdata  in  32  shared-bus read data
- m_hresp  in  1  shared-bus error response
- arb_owner  out  2  data-phase owner: 0 none, 1 I, 2 D

## Operation
- **Requests:** a request is htrans[1]=1. SEQ is treated as NONSEQ, and every forwarded transfer is issued as m_htrans=2'b10. BUSY and IDLE mean no request.
- **Accepting a live request:** a live request from X is accepted only in a cycle where X_hready=1.
- **Pending buffers:** pend_I and pend_D each hold {addr, size, write}.
  - An accepted live request that is not granted is captured in pend_X.
  - While pend_X=1, X's bus inputs are ignored.
- **Candidates:** pend_X, or an accepted live request from X. A master never has both at once.
- **Arbitration:** happens only in cycles with m_hready=1.
  - Single candidate: it wins.
  - Both masters requesting: D wins, unless starve_cnt==STARVE_LIMIT, in which case I wins.
  - The winner drives m_haddr, m_hsize and m_hwrite, from its pend register if set, otherwise from its live inputs.
  - A winning pend_X clears.
  - If there is no candidate, m_htrans=IDLE.
- **Starvation counter (starve_cnt, 4 bit):**
  - Increments when D wins while I is also requesting.
  - Clears when I wins.
  - Holds otherwise.
- **Owner register:** when m_hready=1, owner <= winner, or none if there was no winner.
- **Per-master response:**
  - If owner==X: X_hready=m_hready, X_hresp=m_hresp, X_hrdata=m_hrdata.
  - Otherwise: X_hready=!pend_X, X_hresp=0, X_hrdata=0.
- **Write data:** a buffered D write keeps d_hwdata stable because d_hready is held low. m_hwdata is therefore valid in D's real data phase.
- **Error responses:** the 2-cycle ERROR response is passed through unchanged to the owner. A buffered request of the other master is still issued afterwards.
- **Reset values:** pend_I=pend_D=0, owner=none, starve_cnt=0, m_htrans=IDLE, i_hready=d_hready=1, i_hresp=d_hresp=0, arb_owner=0.
- **Reset mid-transfer:** buffered requests are discarded with no replay; the masters are reset together with the arbiter.

## Timing
- Uncontested live request with the bus free: zero added latency. The combinational path runs from X_h* to m_h*.
- Buffered request: issued in the first later cycle with m_hready=1 in which it wins. The added latency is at least one data phase of the other master.
- X_hready for a buffered request stays low from the cycle after capture until the end of its real data phase.
- Owner changes only in cycles with m_hready=1. Wait states on m_hready freeze arbitration, the buffers and starve_cnt.

## Configuration
- **Macro `NANORV32_ARB_RR_EN`:**
  - Defined: a contest is won by the master not granted most recently (register last_grant, reset value I, so D wins the first contest). starve_cnt and STARVE_LIMIT are unused.
  - Undefined: fixed D priority with the starvation limit described above.

## Test plan
- **Single master, no contention:** I-only reads at 0x100, 0x104 with m_hready=1 → m_haddr follows in the same cycle, i_hready never low, arb_owner=1 in each data phase.
- **Simultaneous requests:** I at 0x200 and D write at 0x8000 (d_hwdata=0xCAFEF00D) in the same cycle → D issued first. I is buffered and issued the next cycle. i_hready is low for exactly 1 cycle. m_hwdata=0xCAFEF00D during D's data phase.
- **Starvation limit:** with STARVE_LIMIT=4, I and D request continuously → the grant sequence is D,D,D,D,I, repeating.
- **Slave wait states:** 3 wait states on a D read while I requests → I held in pend_I. m_haddr does not change until m_hready=1. I is issued on the cycle D completes.
- **Error response:** ERROR response on a D transfer → d_hresp is high for 2 cycles, d_hready is low then high. The buffered I transfer is issued next and completes with OKAY.
- **Round-robin build (with `NANORV32_ARB_RR_EN`):** continuous contention → strict alternation D,I,D,I. After asserting rst mid-transfer, all outputs return to their reset values on the next clk edge.
